// File: rtl/nand_page_word_packer.sv
// nand_page_word_packer: packs NAND data-out bytes little-endian into 32-bit words
// and buffers them in a show-ahead FIFO with page tracking and back-pressure.
module nand_page_word_packer #(
   parameter int PAGE_BYTES = 2112,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_MARGIN  = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PAGE_START,
   input  logic        BYTE_VALID,
   input  logic [7:0]  BYTE_IN,
   output logic        HOLD_RD,
   output logic        WORD_VALID,
   output logic [31:0] WORD_DATA,
   input  logic        WORD_READY,
   output logic        PAGE_DONE,
   output logic [15:0] BYTE_CNT,
   output logic        OVERFLOW,
   output logic        EXTRA_BYTE
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
   state_t state;
   logic [31:0] pack, wdata;
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count;
   logic [1:0] lane;
   logic take, last, push, pop, full, wr;
   assign lane = BYTE_CNT[1:0];
   assign take = state == COLLECT && BYTE_VALID && !PAGE_START;
   assign last = BYTE_CNT == 16'(PAGE_BYTES - 1);
   assign push = (take && lane == 2'd3) || state == FLUSH;
   assign count = wr_ptr - rd_ptr;
   assign full = count == PW'(FIFO_DEPTH);
   assign pop = WORD_READY && |count;
   assign wr = push && (!full || pop);
   // upper lanes of pack are always zero before they are written, so FLUSH pads for free
   assign wdata = state == FLUSH ? pack : {BYTE_IN, pack[23:0]};
   assign WORD_VALID = |count;
   assign WORD_DATA = WORD_VALID ? mem[rd_ptr[AW-1:0]] : '0;
   assign HOLD_RD = PW'(FIFO_DEPTH) - count <= PW'(AF_MARGIN);
   always_ff @(posedge CLK)
      if (wr) mem[wr_ptr[AW-1:0]] <= wdata;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         pack <= '0;
         BYTE_CNT <= '0;
         OVERFLOW <= 1'b0;
         EXTRA_BYTE <= 1'b0;
         PAGE_DONE <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         PAGE_DONE <= 1'b0;
         if (PAGE_START) begin
            state <= COLLECT;
            pack <= '0;
            BYTE_CNT <= '0;
            OVERFLOW <= 1'b0;
            EXTRA_BYTE <= 1'b0;
         end else begin
            if (push && full && !pop) OVERFLOW <= 1'b1;
            if (BYTE_VALID && state != COLLECT) EXTRA_BYTE <= 1'b1;
            case (state)
               IDLE: ;
               COLLECT:
                  if (BYTE_VALID) begin
                     BYTE_CNT <= BYTE_CNT + 1'b1;
                     if (lane == 2'd3) pack <= '0;
                     else pack[8*lane +: 8] <= BYTE_IN;
                     if (last) begin
                        state <= lane == 2'd3 ? DONE : FLUSH;
                        PAGE_DONE <= lane == 2'd3;
                     end
                  end
               FLUSH: begin
                  pack <= '0;
                  state <= DONE;
                  PAGE_DONE <= 1'b1;
               end
               DONE: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_nand_page_word_packer.sv
// tb_nand_page_word_packer: three packers (8-, 6- and 2112-byte pages) share stimulus;
// sel routes control to one, and a word queue scoreboards its FIFO output.
module tb_nand_page_word_packer;
   logic clk = 1'b0, rst = 1'b1;
   logic page_start = 1'b0, byte_valid = 1'b0, word_ready = 1'b0;
   logic [7:0] byte_in = '0;
   logic [2:0] hold, wv, pd, ovf, eb;
   logic [31:0] wd [3];
   logic [15:0] bc [3];
   int sel = 2;
   int checks = 0, errors = 0;
   int pd_cnt = 0, w_cnt = 0;
   logic [31:0] exp_q [$];
   bit use_model = 1'b0;
   logic [31:0] m_pack = '0;
   int m_lane = 0, m_cnt = 0, m_drop = 0;
   typedef struct {
      int sel;
      int n;
      logic [7:0] base;
      int dly;
      logic [31:0] w0, w1;
   } row_t;
   row_t rows [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      nand_page_word_packer #(.PAGE_BYTES(g == 0 ? 8 : g == 1 ? 6 : 2112), .FIFO_DEPTH(16), .AF_MARGIN(2)) dut (
         .CLK(clk), .RST(rst),
         .PAGE_START(page_start && sel == g), .BYTE_VALID(byte_valid && sel == g), .BYTE_IN(byte_in),
         .HOLD_RD(hold[g]), .WORD_VALID(wv[g]), .WORD_DATA(wd[g]),
         .WORD_READY(word_ready && sel == g), .PAGE_DONE(pd[g]), .BYTE_CNT(bc[g]),
         .OVERFLOW(ovf[g]), .EXTRA_BYTE(eb[g])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst) begin
         if (pd[sel]) pd_cnt++;
         if (word_ready && wv[sel]) begin
            w_cnt++;
            if (exp_q.size() == 0) chk("unexpected_word", wd[sel], 32'hxxxxxxxx);
            else chk("word", wd[sel], exp_q.pop_front());
         end
      end

   function automatic int plen();
      return sel == 0 ? 8 : sel == 1 ? 6 : 2112;
   endfunction

   task automatic model_clear();
      m_pack = '0;
      m_lane = 0;
      m_cnt = 0;
   endtask

   task automatic send(input logic [7:0] b);
      byte_in = b;
      byte_valid = 1'b1;
      if (use_model) begin
         m_pack[8*m_lane +: 8] = b;
         m_lane++;
         m_cnt++;
         if (m_lane == 4 || m_cnt == plen()) begin
            if (exp_q.size() == 16 && !word_ready) m_drop++;
            else exp_q.push_back(m_pack);
            model_clear();
            m_cnt = m_cnt == plen() ? plen() : 0;
         end
      end
      @(posedge clk);
      #1 byte_valid = 1'b0;
   endtask

   task automatic pstart();
      page_start = 1'b1;
      @(posedge clk);
      #1 page_start = 1'b0;
      model_clear();
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(posedge clk);
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("drain_wv", 32'(wv[sel]), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rows[0] = '{0, 8, 8'h01, 1, 32'h04030201, 32'h08070605};
      rows[1] = '{1, 6, 8'hAA, 2, 32'hADACABAA, 32'h0000AFAE};
      rows[2] = '{0, 8, 8'hF0, 1, 32'hF3F2F1F0, 32'hF7F6F5F4};
      repeat (3) @(negedge clk);
      chk("rst_flags", 32'({hold[2], wv[2], pd[2], ovf[2], eb[2]}), 32'd0);
      chk("rst_bc", 32'(bc[2]), 32'd0);
      chk("rst_wd", wd[2], 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      // short pages: table of expected words and PAGE_DONE latency
      foreach (rows[r]) begin
         sel = rows[r].sel;
         word_ready = 1'b1;
         use_model = 1'b0;
         exp_q.push_back(rows[r].w0);
         exp_q.push_back(rows[r].w1);
         pstart();
         pd_cnt = 0;
         for (int i = 0; i < rows[r].n; i++) send(rows[r].base + 8'(i));
         for (int k = 1; k <= rows[r].dly; k++) begin
            @(negedge clk);
            chk("page_done_t", 32'(pd[sel]), 32'(k == rows[r].dly));
         end
         repeat (4) @(posedge clk);
         #1;
         chk("pd_count", 32'(pd_cnt), 32'd1);
         chk("byte_cnt", 32'(bc[sel]), 32'(rows[r].n));
         chk("row_left", 32'(exp_q.size()), 32'd0);
      end
      // fill the 16-deep FIFO with no consumer
      sel = 2;
      word_ready = 1'b0;
      use_model = 1'b1;
      pstart();
      for (int i = 0; i < 52; i++) send(8'(i));
      chk("hold_13w", 32'(hold[2]), 32'd0);
      for (int i = 52; i < 56; i++) send(8'(i));
      chk("hold_14w", 32'(hold[2]), 32'd1);
      for (int i = 56; i < 64; i++) send(8'(i));
      chk("full_wv", 32'(wv[2]), 32'd1);
      chk("full_ovf", 32'(ovf[2]), 32'd0);
      chk("full_head", wd[2], 32'h03020100);
      chk("full_bc", 32'(bc[2]), 32'd64);
      for (int i = 64; i < 68; i++) send(8'(i));
      chk("ovf_set", 32'(ovf[2]), 32'd1);
      chk("ovf_head", wd[2], 32'h03020100);
      chk("ovf_bc", 32'(bc[2]), 32'd68);
      chk("ovf_drop", 32'(m_drop), 32'd1);
      pstart();
      chk("ovf_clear", 32'(ovf[2]), 32'd0);
      // push into a full FIFO while the consumer pops in the same cycle
      for (int i = 0; i < 3; i++) send(8'h80 + 8'(i));
      word_ready = 1'b1;
      send(8'h83);
      word_ready = 1'b0;
      chk("pushpop_ovf", 32'(ovf[2]), 32'd0);
      chk("pushpop_hold", 32'(hold[2]), 32'd1);
      chk("pushpop_head", wd[2], 32'h07060504);
      word_ready = 1'b1;
      drain();
      // PAGE_START wins over a simultaneous byte
      pstart();
      for (int i = 0; i < 3; i++) send(8'h55 + 8'(i));
      page_start = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'h99;
      @(posedge clk);
      #1 page_start = 1'b0;
      byte_valid = 1'b0;
      model_clear();
      chk("ps_bc", 32'(bc[2]), 32'd0);
      for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
      chk("ps_q", 32'(exp_q[0]), 32'h13121110);
      drain();
      // asynchronous reset mid-page with a word buffered
      word_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
      rst = 1'b1;
      #2;
      chk("rstmid_flags", 32'({hold[2], wv[2], pd[2], ovf[2], eb[2]}), 32'd0);
      chk("rstmid_bc", 32'(bc[2]), 32'd0);
      chk("rstmid_wd", wd[2], 32'd0);
      exp_q.delete();
      model_clear();
      @(posedge clk);
      #1 rst = 1'b0;
      // stray byte in IDLE, then a full-size page
      use_model = 1'b0;
      send(8'h77);
      chk("extra_set", 32'(eb[2]), 32'd1);
      chk("extra_nopush", 32'(wv[2]), 32'd0);
      pstart();
      chk("extra_clear", 32'(eb[2]), 32'd0);
      use_model = 1'b1;
      word_ready = 1'b1;
      w_cnt = 0;
      pd_cnt = 0;
      for (int i = 0; i < 2112; i++) send(8'($urandom));
      repeat (6) @(posedge clk);
      #1;
      chk("page_words", 32'(w_cnt), 32'd528);
      chk("page_bc", 32'(bc[2]), 32'd2112);
      chk("page_pd", 32'(pd_cnt), 32'd1);
      chk("page_left", 32'(exp_q.size()), 32'd0);
      chk("page_flags", 32'({ovf[2], eb[2]}), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
